// File: rtl/regfile_controller_pkg.sv
// Shared state encodings and default constants for the register-file sequencer.
package regfile_controller_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DBG  = 2'd2
    } state_e;

    localparam int unsigned IDX_W = 5;
    localparam int unsigned XLEN  = 32;

    localparam int unsigned     SP_IDX_DEF    = 2;
    localparam logic [XLEN-1:0] SP_INIT_DEF   = 32'h0000_2ffc;
    localparam int unsigned     ECALL_REG_DEF = 17;
    localparam logic [XLEN-1:0] HALT_CODE_DEF = 32'd10;

    function automatic logic [IDX_W-1:0] to_idx(input int unsigned v);
        return v[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/regfile_controller_init_seq.sv
// Post-reset sweep: walks every register index once, clearing it or loading the stack pointer.
module rf_init_seq
    import regfile_controller_pkg::*;
#(
    parameter int unsigned     NUM_REGS = 32,
    parameter int unsigned     SP_IDX   = SP_IDX_DEF,
    parameter logic [XLEN-1:0] SP_INIT  = SP_INIT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             active_i,
    output logic [IDX_W-1:0] rd_o,
    output logic [XLEN-1:0]  din_o,
    output logic             last_o,
    output logic             done_o
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;

    always_comb begin
        last_o = (idx_q == to_idx(NUM_REGS - 1));
        rd_o   = idx_q;
        din_o  = (idx_q == to_idx(SP_IDX)) ? SP_INIT : '0;
        idx_d  = idx_q;
        done_d = done_q;
        if (active_i) begin
            idx_d = idx_q + IDX_W'(1);
            if (last_o) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/regfile_controller.sv
// Front-end for the 32x32 register file: init sweep, core pass-through,
// single-outstanding debug access and sticky ecall-halt write freeze.
module regfile_controller
    import regfile_controller_pkg::*;
#(
    parameter int unsigned     NUM_REGS  = 32,
    parameter int unsigned     SP_IDX    = SP_IDX_DEF,
    parameter logic [XLEN-1:0] SP_INIT   = SP_INIT_DEF,
    parameter int unsigned     ECALL_REG = ECALL_REG_DEF,
    parameter logic [XLEN-1:0] HALT_CODE = HALT_CODE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] core_rs1,
    input  logic [IDX_W-1:0] core_rs2,
    input  logic [IDX_W-1:0] core_rd,
    input  logic [XLEN-1:0]  core_din,
    input  logic             core_we,
    input  logic             core_ecall,
    output logic [IDX_W-1:0] rf_rs1,
    output logic [IDX_W-1:0] rf_rs2,
    output logic [IDX_W-1:0] rf_rd,
    output logic [XLEN-1:0]  rf_din,
    output logic             rf_we,
    input  logic [XLEN-1:0]  rf_rs1_dout,
    input  logic             dbg_req,
    input  logic             dbg_wr,
    input  logic [IDX_W-1:0] dbg_addr,
    input  logic [XLEN-1:0]  dbg_wdata,
    output logic             dbg_ack,
    output logic [XLEN-1:0]  dbg_rdata,
    output logic             core_stall,
    output logic             init_done,
    output logic             is_halted
);

    state_e          state_q;
    logic            halted_q;
    logic            dbg_ack_q;
    logic [XLEN-1:0] dbg_rdata_q;

    logic [IDX_W-1:0] init_rd;
    logic [XLEN-1:0]  init_din;
    logic             init_last;
    logic             halt_hit;

    rf_init_seq #(
        .NUM_REGS (NUM_REGS),
        .SP_IDX   (SP_IDX),
        .SP_INIT  (SP_INIT)
    ) u_init_seq (
        .clk_i    (clk),
        .rst_ni   (reset),
        .active_i (state_q == ST_INIT),
        .rd_o     (init_rd),
        .din_o    (init_din),
        .last_o   (init_last),
        .done_o   (init_done)
    );

    // Port steering; the INIT write enable is gated by reset so it drops the instant reset asserts.
    always_comb begin
        rf_rs1 = core_rs1;
        rf_rs2 = core_rs2;
        rf_rd  = core_rd;
        rf_din = core_din;
        rf_we  = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                rf_rd  = init_rd;
                rf_din = init_din;
                rf_we  = reset;
            end
            ST_RUN: begin
                if (core_ecall) begin
                    rf_rs1 = to_idx(ECALL_REG);
                end
                rf_we = core_we & ~halted_q & ~core_ecall & (core_rd != '0);
            end
            ST_DBG: begin
                if (dbg_wr) begin
                    rf_rd  = dbg_addr;
                    rf_din = dbg_wdata;
                    rf_we  = (dbg_addr != '0);
                end else begin
                    rf_rs1 = dbg_addr;
                end
            end
            default: ;
        endcase
    end

    assign halt_hit = (state_q == ST_RUN) & core_ecall & (rf_rs1_dout == HALT_CODE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            halted_q    <= 1'b0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            dbg_ack_q <= 1'b0;
            if (halt_hit) begin
                halted_q <= 1'b1;
            end
            unique case (state_q)
                ST_INIT: begin
                    if (init_last) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The ack cycle blocks a re-grant of a request the requester has not yet dropped.
                    if (dbg_req && !dbg_ack_q) begin
                        state_q <= ST_DBG;
                    end
                end
                ST_DBG: begin
                    state_q   <= ST_RUN;
                    dbg_ack_q <= 1'b1;
                    if (!dbg_wr) begin
                        dbg_rdata_q <= rf_rs1_dout;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign dbg_ack    = dbg_ack_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign is_halted  = halted_q;
    assign core_stall = (state_q != ST_RUN) | halted_q;

endmodule

// File: tb/tb_regfile_controller.sv
// Directed bench for regfile_controller with a behavioural 32x32 register file attached.
module tb_regfile_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  core_rs1, core_rs2, core_rd;
    logic [31:0] core_din;
    logic        core_we, core_ecall;
    logic [4:0]  rf_rs1, rf_rs2, rf_rd;
    logic [31:0] rf_din;
    logic        rf_we;
    logic [31:0] rf_rs1_dout;
    logic        dbg_req, dbg_wr;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        core_stall, init_done, is_halted;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf_mem [32];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_rd] <= rf_din;
    end
    assign rf_rs1_dout = rf_mem[rf_rs1];

    regfile_controller dut (
        .clk         (clk),
        .reset       (reset),
        .core_rs1    (core_rs1),
        .core_rs2    (core_rs2),
        .core_rd     (core_rd),
        .core_din    (core_din),
        .core_we     (core_we),
        .core_ecall  (core_ecall),
        .rf_rs1      (rf_rs1),
        .rf_rs2      (rf_rs2),
        .rf_rd       (rf_rd),
        .rf_din      (rf_din),
        .rf_we       (rf_we),
        .rf_rs1_dout (rf_rs1_dout),
        .dbg_req     (dbg_req),
        .dbg_wr      (dbg_wr),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_ack     (dbg_ack),
        .dbg_rdata   (dbg_rdata),
        .core_stall  (core_stall),
        .init_done   (init_done),
        .is_halted   (is_halted)
    );

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] din;
        logic        we;
        logic        ecall;
        logic        exp_we;
        logic [4:0]  exp_rs1;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        core_rs1 = '0; core_rs2 = '0; core_rd = '0; core_din = '0;
        core_we = 1'b0; core_ecall = 1'b0;
        dbg_req = 1'b0; dbg_wr = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1 with reset just released; leaves after one RUN cycle.
    task automatic run_init(input string tag);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk({tag, "_we"}, 32'(rf_we), 32'd1);
            chk({tag, "_rd"}, 32'(rf_rd), 32'(i));
            chk({tag, "_din"}, rf_din, (i == 2) ? 32'h2ffc : 32'h0);
            chk({tag, "_stall"}, 32'(core_stall), 32'd1);
            chk({tag, "_done_low"}, 32'(init_done), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk({tag, "_done"}, 32'(init_done), 32'd1);
        chk({tag, "_we_after"}, 32'(rf_we), 32'd0);
        chk({tag, "_stall_after"}, 32'(core_stall), 32'd0);
        next_cycle();
    endtask

    task automatic dbg_txn(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                           input logic exp_we, input logic [31:0] exp_rdata, input string tag);
        dbg_req = 1'b1; dbg_wr = wr; dbg_addr = addr; dbg_wdata = wdata;
        next_cycle();
        @(negedge clk);
        chk({tag, "_stall"}, 32'(core_stall), 32'd1);
        chk({tag, "_we"}, 32'(rf_we), 32'(exp_we));
        chk({tag, "_ack_early"}, 32'(dbg_ack), 32'd0);
        if (wr) begin
            chk({tag, "_rd"}, 32'(rf_rd), 32'(addr));
            chk({tag, "_din"}, rf_din, wdata);
        end else begin
            chk({tag, "_rs1"}, 32'(rf_rs1), 32'(addr));
        end
        next_cycle();
        dbg_req = 1'b0;
        @(negedge clk);
        chk({tag, "_ack"}, 32'(dbg_ack), 32'd1);
        if (!wr) chk({tag, "_rdata"}, dbg_rdata, exp_rdata);
        next_cycle();
        @(negedge clk);
        chk({tag, "_ack_pulse"}, 32'(dbg_ack), 32'd0);
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{5'd1, 5'd2, 5'd0,  32'h0000_DEAD, 1'b1, 1'b0, 1'b0, 5'd1};
        vecs[1] = '{5'd3, 5'd4, 5'd5,  32'h0000_1234, 1'b1, 1'b0, 1'b1, 5'd3};
        vecs[2] = '{5'd5, 5'd6, 5'd7,  32'h0000_CAFE, 1'b1, 1'b0, 1'b1, 5'd5};
        vecs[3] = '{5'd7, 5'd0, 5'd17, 32'h0000_0009, 1'b1, 1'b0, 1'b1, 5'd7};
        vecs[4] = '{5'd8, 5'd9, 5'd9,  32'h0000_ABCD, 1'b0, 1'b0, 1'b0, 5'd8};
        vecs[5] = '{5'd4, 5'd1, 5'd0,  32'h0000_0000, 1'b0, 1'b1, 1'b0, 5'd17};

        reset = 1'b0;
        idle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_stall", 32'(core_stall), 32'd1);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_ack", 32'(dbg_ack), 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_halted", 32'(is_halted), 32'd0);
        next_cycle();
        reset = 1'b1;
        run_init("init");

        for (int v = 0; v < 6; v++) begin
            core_rs1 = vecs[v].rs1; core_rs2 = vecs[v].rs2; core_rd = vecs[v].rd;
            core_din = vecs[v].din; core_we = vecs[v].we; core_ecall = vecs[v].ecall;
            @(negedge clk);
            chk($sformatf("vec%0d_we", v), 32'(rf_we), 32'(vecs[v].exp_we));
            chk($sformatf("vec%0d_rs1", v), 32'(rf_rs1), 32'(vecs[v].exp_rs1));
            chk($sformatf("vec%0d_rs2", v), 32'(rf_rs2), 32'(vecs[v].rs2));
            chk($sformatf("vec%0d_rd", v), 32'(rf_rd), 32'(vecs[v].rd));
            chk($sformatf("vec%0d_din", v), rf_din, vecs[v].din);
            chk($sformatf("vec%0d_stall", v), 32'(core_stall), 32'd0);
            next_cycle();
        end
        idle();
        @(negedge clk);
        chk("ecall_x17_9_no_halt", 32'(is_halted), 32'd0);
        chk("ecall_x17_9_stall", 32'(core_stall), 32'd0);
        next_cycle();

        // Debug read of x7 with the request held into the ack cycle.
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd7;
        @(negedge clk);
        chk("dbgrd_pre_stall", 32'(core_stall), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("dbgrd_stall", 32'(core_stall), 32'd1);
        chk("dbgrd_rs1", 32'(rf_rs1), 32'd7);
        chk("dbgrd_we", 32'(rf_we), 32'd0);
        chk("dbgrd_ack_early", 32'(dbg_ack), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("dbgrd_ack", 32'(dbg_ack), 32'd1);
        chk("dbgrd_rdata", dbg_rdata, 32'h0000_CAFE);
        chk("dbgrd_ack_stall", 32'(core_stall), 32'd0);
        next_cycle();
        dbg_req = 1'b0;
        @(negedge clk);
        chk("dbgrd_no_regrant_ack", 32'(dbg_ack), 32'd0);
        chk("dbgrd_no_regrant_stall", 32'(core_stall), 32'd0);
        next_cycle();

        dbg_txn(1'b1, 5'd9, 32'hBEEF_0001, 1'b1, 32'h0, "dbgwr_x9");
        dbg_txn(1'b0, 5'd9, 32'h0, 1'b0, 32'hBEEF_0001, "dbgrd_x9");
        dbg_txn(1'b1, 5'd0, 32'h1111_2222, 1'b0, 32'h0, "dbgwr_x0");
        dbg_txn(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, "dbgrd_x0");

        // Ecall with x17 == 10 halts and freezes core writes.
        core_rd = 5'd17; core_din = 32'd10; core_we = 1'b1;
        next_cycle();
        core_we = 1'b0; core_ecall = 1'b1; core_rs1 = 5'd4;
        @(negedge clk);
        chk("halt_ecall_rs1", 32'(rf_rs1), 32'd17);
        chk("halt_ecall_cycle", 32'(is_halted), 32'd0);
        chk("halt_ecall_stall", 32'(core_stall), 32'd0);
        next_cycle();
        core_ecall = 1'b0; core_we = 1'b1; core_rd = 5'd5; core_din = 32'h0000_FFFF;
        @(negedge clk);
        chk("halt_flag", 32'(is_halted), 32'd1);
        chk("halt_stall", 32'(core_stall), 32'd1);
        chk("halt_we_frozen", 32'(rf_we), 32'd0);
        next_cycle();
        idle();
        dbg_txn(1'b1, 5'd3, 32'h0000_0055, 1'b1, 32'h0, "halt_dbgwr");
        dbg_txn(1'b0, 5'd3, 32'h0, 1'b0, 32'h0000_0055, "halt_dbgrd");
        @(negedge clk);
        chk("halt_sticky", 32'(is_halted), 32'd1);
        next_cycle();

        // Reset in the middle of the sweep at idx 12.
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        repeat (12) next_cycle();
        @(negedge clk);
        chk("midinit_rd12", 32'(rf_rd), 32'd12);
        chk("midinit_we", 32'(rf_we), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("midinit_we_drop", 32'(rf_we), 32'd0);
        chk("midinit_done", 32'(init_done), 32'd0);
        chk("midinit_halt_clr", 32'(is_halted), 32'd0);
        next_cycle();
        reset = 1'b1;
        run_init("reinit");

        // Ecall-halt and debug grant in the same RUN cycle.
        core_rd = 5'd17; core_din = 32'd10; core_we = 1'b1;
        next_cycle();
        core_we = 1'b0; core_ecall = 1'b1;
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd17;
        @(negedge clk);
        chk("simul_rs1", 32'(rf_rs1), 32'd17);
        chk("simul_pre_halt", 32'(is_halted), 32'd0);
        next_cycle();
        core_ecall = 1'b0;
        @(negedge clk);
        chk("simul_halted", 32'(is_halted), 32'd1);
        chk("simul_dbg_stall", 32'(core_stall), 32'd1);
        chk("simul_dbg_rs1", 32'(rf_rs1), 32'd17);
        chk("simul_ack_early", 32'(dbg_ack), 32'd0);
        next_cycle();
        dbg_req = 1'b0;
        @(negedge clk);
        chk("simul_ack", 32'(dbg_ack), 32'd1);
        chk("simul_rdata", dbg_rdata, 32'd10);
        chk("simul_still_halted", 32'(is_halted), 32'd1);
        next_cycle();

        // Reset during the DBG cycle drops the pending access without an ack.
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        repeat (33) next_cycle();
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd2;
        next_cycle();
        @(negedge clk);
        chk("middbg_stall", 32'(core_stall), 32'd1);
        chk("middbg_rs1", 32'(rf_rs1), 32'd2);
        #1 reset = 1'b0;
        #1;
        chk("middbg_ack_rst", 32'(dbg_ack), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("middbg_no_ack", 32'(dbg_ack), 32'd0);
        chk("middbg_rdata", dbg_rdata, 32'd0);
        chk("middbg_done", 32'(init_done), 32'd0);
        idle();
        next_cycle();
        reset = 1'b1;
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
